// File: rtl/cgra_cfg_pkg.sv
// Shared types and helpers for the CGRA configuration write path.
package cgra_cfg_pkg;

   localparam int unsigned NREQ_DEF = 4;
   localparam int unsigned NREG_DEF = 16;
   localparam int unsigned AW_DEF   = 4;
   localparam int unsigned DW_DEF   = 32;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // One bit of a one-hot decode: high when position pos is selected by idx.
   function automatic logic onehot_dec(input int unsigned idx, input int unsigned pos);
      return idx == pos;
   endfunction

endpackage

// File: rtl/cgra_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping.
module cgra_rr_pick
   import cgra_cfg_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt_oh,
   output logic [$clog2(NREQ)-1:0] gnt_idx,
   output logic                    any
);

   localparam int unsigned IW = $clog2(NREQ);

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         int unsigned j;
         j = (32'(ptr) + i) % NREQ;
         if (!any && req[j]) begin
            any        = 1'b1;
            gnt_oh[j]  = 1'b1;
            gnt_idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/cgra_cfg_wr_arb.sv
// Round-robin write arbiter with locked bursts for the CGRA config register bank.
module cgra_cfg_wr_arb
   import cgra_cfg_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned DW   = DW_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*AW-1:0]      req_addr,
   input  logic [NREQ*DW-1:0]      req_data,
   input  logic [NREQ-1:0]         req_last,
   input  logic                    cfg_hold,
   output logic [NREG-1:0]         cfg_lden,
   output logic [DW-1:0]           cfg_wdata,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    err_addr
);

   localparam int unsigned IW = $clog2(NREQ);

   arb_state_e      state, state_n;
   logic [IW-1:0]   rr_ptr, rr_ptr_n;
   logic [IW-1:0]   owner, owner_n;

   logic [NREQ-1:0] pick_oh;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;

   logic            accept_c;
   logic [IW-1:0]   acc_idx_c;
   logic [AW-1:0]   beat_addr_c;
   logic [DW-1:0]   beat_data_c;
   logic            beat_last_c;
   logic            addr_bad_c;
   logic [NREG-1:0] lden_c;

   cgra_rr_pick #(.NREQ(NREQ)) u_pick (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt_oh  (pick_oh),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
      end else begin
         state  <= state_n;
         rr_ptr <= rr_ptr_n;
         owner  <= owner_n;
      end
   end

   // Pointer advances only when a burst closes; a locked owner is remembered.
   always_comb begin
      state_n  = state;
      rr_ptr_n = rr_ptr;
      owner_n  = owner;
      if (accept_c) begin
         if (beat_last_c) begin
            state_n  = IDLE;
            rr_ptr_n = (acc_idx_c == IW'(NREQ - 1)) ? '0 : acc_idx_c + IW'(1);
         end else if (state == IDLE) begin
            state_n = LOCK;
            owner_n = acc_idx_c;
         end
      end
   end

   // Ready generation and selection of the accepted beat.
   always_comb begin
      req_ready   = '0;
      acc_idx_c   = pick_idx;
      beat_addr_c = '0;
      beat_data_c = '0;
      beat_last_c = 1'b0;
      lden_c      = '0;
      if (state == IDLE) begin
         if (!cfg_hold && pick_any) req_ready = pick_oh;
      end else begin
         acc_idx_c = owner;
         if (!cfg_hold && req_valid[owner]) req_ready[owner] = 1'b1;
      end
      accept_c = |req_ready;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (acc_idx_c == IW'(i)) begin
            beat_addr_c = req_addr[i*AW +: AW];
            beat_data_c = req_data[i*DW +: DW];
            beat_last_c = req_last[i];
         end
      end
      addr_bad_c = (32'(beat_addr_c) >= NREG);
      for (int unsigned r = 0; r < NREG; r++) begin
         lden_c[r] = !addr_bad_c && onehot_dec(32'(beat_addr_c), r);
      end
   end

   // Write port: strobes pulse per beat, data and id hold between beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_lden  <= '0;
         err_addr  <= 1'b0;
         cfg_wdata <= '0;
         grant_id  <= '0;
      end else begin
         cfg_lden <= accept_c ? lden_c : '0;
         err_addr <= accept_c && addr_bad_c;
         if (accept_c) begin
            cfg_wdata <= beat_data_c;
            grant_id  <= acc_idx_c;
         end
      end
   end

endmodule

// File: doc/cgra_cfg_wr_arb.md
# cgra_cfg_wr_arb

Round-robin write arbiter for the CGRA configuration register bank. It shares one registered write port, a load-enable vector plus a data bus, among NREQ requesters. Each register in the bank is a plain load-enable flop: it loads `cfg_wdata` when its `cfg_lden` bit is high. The arbiter supports locked multi-beat bursts, so one requester can write a full PE context without interleaving. It sits between the core's CSR/DMA config masters and the bank.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `NREG`, 16: registers in the bank.
- `AW`, 4: register index width; NREG ≤ 2^AW.
- `DW`, 32: data width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester write request.
- `req_ready` out NREQ: per-requester accept (combinational).
- `req_addr` in NREQ*AW: packed register index; requester i uses slice [i*AW +: AW].
- `req_data` in NREQ*DW: packed write data.
- `req_last` in NREQ: beat ends the burst; 0 keeps the lock.
- `cfg_hold` in 1: bank busy; no beat is accepted while high.
- `cfg_lden` out NREG: one-hot-or-zero load enable, registered.
- `cfg_wdata` out DW: registered write data.
- `grant_id` out $clog2(NREQ): owner of the most recent accepted beat.
- `err_addr` out 1: one-cycle pulse when the accepted beat had addr ≥ NREG.

## Operation
- States:
  - IDLE: no lock.
  - LOCK: burst in progress; `owner` is captured.
- IDLE:
  - Pick the first valid requester scanning from `rr_ptr` upward, wrapping modulo NREQ.
  - If `cfg_hold`=0, assert `req_ready[pick]` only; all other ready bits are 0.
  - An accepted beat with `req_last`=1 stays in IDLE and sets `rr_ptr` = pick+1 mod NREQ.
  - An accepted beat with `req_last`=0 goes to LOCK with `owner` = pick.
- LOCK:
  - Only `req_ready[owner]` can be 1, and only when `req_valid[owner]` and `cfg_hold`=0.
  - Other requesters wait even if valid.
  - A beat with `req_last`=1 returns to IDLE and sets `rr_ptr` = owner+1.
  - The owner dropping valid mid-burst holds LOCK indefinitely; there is no timeout.
- Accepted beat (valid & ready) takes effect on the next edge:
  - `cfg_lden` = onehot(addr) if addr < NREG, else 0.
  - `err_addr` = (addr ≥ NREG).
  - `cfg_wdata` = data.
  - `grant_id` = accepted index.
- No accepted beat: `cfg_lden`=0 and `err_addr`=0. `cfg_wdata` and `grant_id` hold.
- `rr_ptr` changes only at burst end. A pointer at NREQ-1 wraps to 0.
- Asynchronous reset takes effect in any state, including mid-burst:
  - State goes to IDLE, `rr_ptr`=0, `owner`=0.
  - All outputs are 0.
  - In-flight bursts are abandoned; requesters must restart.

## Timing
- Accept-to-load latency is 1 cycle: beat accepted in cycle n, `cfg_lden`/`cfg_wdata` valid in cycle n+1, bank updated at the end of n+1.
- Throughput is one beat per cycle. Back-to-back bursts from different requesters need no bubble: the IDLE pick happens in the cycle after a last beat.
- `req_ready` depends combinationally on `req_valid`, state, `rr_ptr` and `cfg_hold`. It never depends on `req_data` or `req_addr`.
- `cfg_hold` rising in cycle n blocks acceptance in cycle n. The load from the beat accepted in cycle n-1 still occurs in cycle n.
- Single-requester case: a requester valid every cycle with `req_last`=1 is accepted every cycle.

## Structure
- Package `cgra_cfg_pkg` holds:
  - state enum {IDLE, LOCK}, 1 bit;
  - default NREQ/NREG/AW/DW constants;
  - a `onehot_dec` function.
- Sub-module `cgra_rr_pick`, combinational: inputs `req` (NREQ) and `ptr`; outputs `gnt_oh`, `gnt_idx`, `any`. It is reusable by the other CGRA arbiters.
- Output registers use load-enable flops with reset to 0. State, `rr_ptr` and `owner` use plain async-reset flops.

## Test plan
- Reset mid-burst:
  - Stimulus: req1 accepted with last=0 at addr 3, then `rst_n` pulsed low.
  - Required: all outputs 0, state IDLE, `rr_ptr`=0.
  - After release: valid req2 with last=1 is granted first.
- Round-robin:
  - Stimulus: all 4 requesters continuously valid, last=1.
  - Required: grants 0,1,2,3,0,… one per cycle; `cfg_lden` matches each requester's address one cycle later.
- Locked burst:
  - Stimulus: req2 sends 3 beats (addr 5,6,7; last on the 3rd) while req0 and req3 stay valid.
  - Required: req0 and req3 ready=0 for all 3 beats; `cfg_lden` = 0x20, 0x40, 0x80 on consecutive cycles; next grant is req3.
- Hold:
  - Stimulus: `cfg_hold`=1 for 3 cycles with req1 valid.
  - Required: ready=0 and `cfg_lden`=0 during the hold; accepted in the first cycle `cfg_hold`=0, load one cycle later.
- Bad address:
  - Stimulus: NREG=12, req0 addr 13, data 0xDEADBEEF.
  - Required: beat accepted, `cfg_lden`=0, `err_addr`=1 for one cycle, `cfg_wdata`=0xDEADBEEF.
- Pointer wrap:
  - Stimulus: only req3 valid (last=1), then req0 and req3 valid together.
  - Required: req0 granted before req3.
